// File: rtl/clock_timekeeper_pkg.sv
// Shared definitions for the timekeeping core: edit-field encodings,
// field limits and a wrapping step helper used by the set-mode edits.
package clock_pkg;

  typedef enum logic [1:0] {
    LOC_MIN  = 2'd0,
    LOC_HR   = 2'd1,
    LOC_SEC  = 2'd2,
    LOC_NONE = 2'd3
  } loc_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] HR_MAX  = 6'd23;
  localparam logic [5:0] HR_NOON = 6'd12;

  // Step a field up or down by one, wrapping between 0 and max.
  function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                           input logic [5:0] max,
                                           input logic       up);
    if (up) begin
      return (v == max) ? 6'd0 : v + 6'd1;
    end
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// Bundle between the button/mode logic, the timekeeper and the display
// driver. The master side drives controls and reads the display outputs.
interface clock_timekeeper_if;
  import clock_pkg::*;

  logic       set_mode;
  loc_t       loc;
  logic       inc;
  logic       dec;
  logic       mode_12h;
  logic [3:0] hour_upper;
  logic [3:0] hour_lower;
  logic [3:0] minute_upper;
  logic [3:0] minute_lower;
  logic [3:0] second_upper;
  logic [3:0] second_lower;
  logic       pm;
  logic       colon;
  logic       sec_tick;
  logic       day_wrap;

  modport master (
    output set_mode, loc, inc, dec, mode_12h,
    input  hour_upper, hour_lower, minute_upper, minute_lower,
           second_upper, second_lower, pm, colon, sec_tick, day_wrap
  );

  modport slave (
    input  set_mode, loc, inc, dec, mode_12h,
    output hour_upper, hour_lower, minute_upper, minute_lower,
           second_upper, second_lower, pm, colon, sec_tick, day_wrap
  );

endinterface

// File: rtl/clock_timekeeper_bin60_to_bcd.sv
// Combinational split of a 0..59 binary value into tens and ones BCD digits.
module bin60_to_bcd (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] base;

  // Pick the tens digit by range, then subtract its weight for the ones digit.
  always_comb begin
    tens = 4'd0;
    base = 6'd0;
    if (bin >= 6'd50) begin
      tens = 4'd5;
      base = 6'd50;
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      base = 6'd40;
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      base = 6'd30;
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      base = 6'd20;
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      base = 6'd10;
    end
    ones = 4'(bin - base);
  end

endmodule

// File: rtl/clock_timekeeper.sv
// Prescaled hh:mm:ss timekeeper with 12/24-hour display mapping, field-wise
// set mode, colon blink and one-cycle second / day-wrap pulses.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  clock_timekeeper_if.slave  bus
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(TICK_DIV / 2);

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [5:0]       sec, sec_d;
  logic [5:0]       min, min_d;
  logic [5:0]       hr, hr_d;
  logic             prev_set;
  logic             sec_tick, tick_d;
  logic             day_wrap, wrap_d;
  logic             edit_up, edit_dn;
  logic [5:0]       hr_disp;

  // Simultaneous inc and dec cancel out.
  assign edit_up = bus.inc & ~bus.dec;
  assign edit_dn = bus.dec & ~bus.inc;

  // Next-state: frozen edits in set mode, otherwise prescaler and carry chain.
  always_comb begin
    cnt_d  = cnt;
    sec_d  = sec;
    min_d  = min;
    hr_d   = hr;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.set_mode) begin
      cnt_d = '0;
      if (!prev_set) begin
        sec_d = 6'd0;
      end
      if (edit_up || edit_dn) begin
        case (bus.loc)
          LOC_MIN: min_d = wrap_step(min, MIN_MAX, edit_up);
          LOC_HR:  hr_d  = wrap_step(hr, HR_MAX, edit_up);
          LOC_SEC: sec_d = 6'd0;
          default: ;
        endcase
      end
    end else if (cnt == TICK_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (sec == SEC_MAX) begin
        sec_d = 6'd0;
        if (min == MIN_MAX) begin
          min_d = 6'd0;
          if (hr == HR_MAX) begin
            hr_d   = 6'd0;
            wrap_d = 1'b1;
          end else begin
            hr_d = hr + 6'd1;
          end
        end else begin
          min_d = min + 6'd1;
        end
      end else begin
        sec_d = sec + 6'd1;
      end
    end else begin
      cnt_d = cnt + 1'b1;
    end
  end

  // Time registers and pulses; reset clears everything without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sec      <= 6'd0;
      min      <= 6'd0;
      hr       <= 6'd0;
      prev_set <= 1'b0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      sec      <= sec_d;
      min      <= min_d;
      hr       <= hr_d;
      prev_set <= bus.set_mode;
      sec_tick <= tick_d;
      day_wrap <= wrap_d;
    end
  end

  // Map the internal 24-hour value onto 12-hour display when requested.
  always_comb begin
    hr_disp = hr;
    if (bus.mode_12h) begin
      if (hr == 6'd0) begin
        hr_disp = HR_NOON;
      end else if (hr > HR_NOON) begin
        hr_disp = hr - HR_NOON;
      end
    end
  end

  logic [3:0] hu, hl, mu, ml, su, sl;

  bin60_to_bcd u_hr_bcd  (.bin(hr_disp), .tens(hu), .ones(hl));
  bin60_to_bcd u_min_bcd (.bin(min),     .tens(mu), .ones(ml));
  bin60_to_bcd u_sec_bcd (.bin(sec),     .tens(su), .ones(sl));

  assign bus.hour_upper   = hu;
  assign bus.hour_lower   = hl;
  assign bus.minute_upper = mu;
  assign bus.minute_lower = ml;
  assign bus.second_upper = su;
  assign bus.second_lower = sl;
  assign bus.pm           = (hr >= HR_NOON);
  assign bus.colon        = bus.set_mode | (cnt < TICK_HALF);
  assign bus.sec_tick     = sec_tick;
  assign bus.day_wrap     = day_wrap;

endmodule
